load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
- REQ-001 The block SHALL have parameter MEM_BYTES, default 2048, giving the data-memory size in bytes; it is a power of two and a multiple of 4.
- REQ-002 Port clock, input, 1 bit: sole clock; all state SHALL change on its rising edge.
- REQ-003 Port reset_n, input, 1 bit: reset, SHALL be asynchronous and active-low.
- REQ-004 Port start, input, 1 bit: request strobe, sampled only in IDLE.
- REQ-005 Port is_store, input, 1 bit: 1 means store, 0 means load.
- REQ-006 Port size, input, 2 bits: 00 byte, 01 halfword, 10 word; 11 is illegal.
- REQ-007 Port unsigned_ld, input, 1 bit: 1 zero-extends and 0 sign-extends sub-word loads.
- REQ-008 Port address, input, 32 bits: byte address.
- REQ-009 Port store_data, input, 32 bits: store value, right-justified.
- REQ-010 Port busy, output, 1 bit: high in any state other than IDLE.
- REQ-011 Port done, output, 1 bit: one-cycle completion pulse.
- REQ-012 Port error, output, 1 bit: qualifies done; high means the request was rejected.
- REQ-013 Port load_data, output, 32 bits: extended load result, valid when done=1.
- REQ-014 Port mem_address, output, 32 bits: word-aligned memory address.
- REQ-015 Port mem_write_data, output, 32 bits: full word to the memory.
- REQ-016 Port MemRead, output, 1 bit: memory read enable.
- REQ-017 Port MemWrite, output, 1 bit: memory write enable.
- REQ-018 Port mem_read_data, input, 32 bits: memory word, valid the cycle after a MemRead cycle.

Function
- REQ-019 The FSM SHALL have states IDLE, RD, RESP, WR and DONE.
- REQ-020 Request capture: IDLE with start=1 SHALL latch is_store, size, unsigned_ld, address and store_data.
- REQ-021 Accepted-request transitions:
  - word store SHALL go to WR;
  - every other legal request SHALL go to RD;
  - a rejected request SHALL go to DONE with error=1.
- REQ-022 Memory-side outputs:
  - mem_address SHALL be {latched address[31:2], 2'b00};
  - MemRead SHALL be 1 only in RD;
  - MemWrite SHALL be 1 only in WR;
  - MemRead and MemWrite SHALL never be high together.
- REQ-023 Flow: RD SHALL go to RESP. RESP with a load SHALL register load_data and go to DONE. RESP with a byte/halfword store SHALL merge and go to WR. WR SHALL go to DONE. DONE SHALL pulse done for one cycle and go to IDLE.
- REQ-024 Byte lane order is big-endian: byte offset 0 SHALL be bits[31:24] and offset 3 SHALL be bits[7:0]; halfword offset 0 SHALL be bits[31:16].
- REQ-025 Load extraction SHALL select the addressed byte or halfword and sign- or zero-extend it per unsigned_ld; word loads SHALL pass through unmodified.
- REQ-026 Sub-word stores SHALL be read-modify-write: only the addressed lanes of the read word are replaced by store_data[7:0] or [15:0], and all other bytes are preserved.
- REQ-027 Latency from the start cycle to the done cycle SHALL be:
  - word store: 2 cycles;
  - load: 3 cycles;
  - byte/halfword store: 4 cycles;
  - rejected request: 1 cycle.
- REQ-028 start while busy=1 SHALL be ignored and SHALL NOT be queued.
- REQ-029 Rejection conditions: size=11, or address > MEM_BYTES-4 for a word-aligned word or the equivalent end-of-range for the access size, SHALL be rejected without any memory access.
- REQ-030 load_data SHALL hold its value until the next successful load completes; a rejected request or a store SHALL leave it unchanged.

Reset
- REQ-031 On reset_n=0 the block SHALL, immediately and asynchronously:
  - enter IDLE;
  - drive busy, done, error, MemRead and MemWrite to 0;
  - drive load_data, mem_address and mem_write_data to 0.
- REQ-032 Reset during RD, RESP or WR SHALL abandon the request with no memory write and no done pulse.

Configuration
- REQ-033 With LSU_MISALIGN_TRAP_EN defined, the block SHALL reject misaligned halfword (address[0]=1) and word (address[1:0]!=0) requests as in REQ-029.
- REQ-034 Without LSU_MISALIGN_TRAP_EN, halfword accesses SHALL ignore address[0] and word accesses SHALL ignore address[1:0], with no error from misalignment.

Verification
- REQ-035 Load word: memory word at 0x10 = 0x11223344, word load at address 0x10 -> MemRead high 1 cycle, done 3 cycles after start, load_data=0x11223344, error=0.
- REQ-036 Signed byte load: same memory, signed byte load at 0x13 with word=0x112233F4 -> load_data=0xFFFFFFF4; the same request with unsigned_ld=1 -> load_data=0x000000F4.
- REQ-037 Byte store: byte store of 0xAA at 0x11 over 0x11223344 -> RD then WR, mem_write_data=0x11AA3344, done 4 cycles after start.
- REQ-038 Misaligned word: with the macro defined, word store at 0x12 -> done with error=1 after 1 cycle, MemWrite never high; without the macro, the write goes to 0x10.
- REQ-039 Out of range: word load at 0x800 with MEM_BYTES=2048 -> error=1, MemRead never high.
- REQ-040 Reset mid-operation: reset_n low during WR of a halfword store -> MemWrite drops at once, no done pulse, memory unchanged; a subsequent start is accepted normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: byte, halfword and word accesses to a word-wide data memory, big-endian lanes,
// read-modify-write for sub-word stores. Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 2048
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] load_data,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] mem_read_data
);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
  localparam logic [1:0]  SZ_BYTE   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_WORD   = 2'b10;
  localparam logic [1:0]  SZ_BAD    = 2'b11;

  typedef enum logic [2:0] {IDLE, RD, RESP, WR, DONE} state_t;

  state_t      state, state_nxt;
  logic        req_store, req_unsigned;
  logic [1:0]  req_size, req_off;
  logic [15:0] req_data;
  logic        capture_c, reject_c, err_nxt;
  logic [31:0] load_nxt, wdata_nxt, ext_c, merge_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // With misalignment ignored, every size goes out of range exactly when address >= MEM_BYTES.
  always_comb begin
    reject_c = (size == SZ_BAD) || (address >= MEM_LIMIT);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((size == SZ_HALF && address[0]) || (size == SZ_WORD && address[1:0] != 2'b00))
      reject_c = 1'b1;
`endif
  end

  // Lane extraction for loads and lane merge for sub-word stores; offset 0 is the MSB lane.
  always_comb begin
    case (req_off)
      2'd0:    byte_c = mem_read_data[31:24];
      2'd1:    byte_c = mem_read_data[23:16];
      2'd2:    byte_c = mem_read_data[15:8];
      default: byte_c = mem_read_data[7:0];
    endcase
    half_c = req_off[1] ? mem_read_data[15:0] : mem_read_data[31:16];

    case (req_size)
      SZ_BYTE: ext_c = req_unsigned ? {24'd0, byte_c} : {{24{byte_c[7]}}, byte_c};
      SZ_HALF: ext_c = req_unsigned ? {16'd0, half_c} : {{16{half_c[15]}}, half_c};
      default: ext_c = mem_read_data;
    endcase

    merge_c = mem_read_data;
    if (req_size == SZ_BYTE) begin
      case (req_off)
        2'd0:    merge_c[31:24] = req_data[7:0];
        2'd1:    merge_c[23:16] = req_data[7:0];
        2'd2:    merge_c[15:8]  = req_data[7:0];
        default: merge_c[7:0]   = req_data[7:0];
      endcase
    end else if (req_off[1]) begin
      merge_c[15:0] = req_data;
    end else begin
      merge_c[31:16] = req_data;
    end
  end

  // Next state plus next values of the registered outputs.
  always_comb begin
    state_nxt = state;
    capture_c = 1'b0;
    err_nxt   = 1'b0;
    load_nxt  = load_data;
    wdata_nxt = mem_write_data;
    case (state)
      IDLE: begin
        if (start) begin
          capture_c = 1'b1;
          if (reject_c) begin
            state_nxt = DONE;
            err_nxt   = 1'b1;
          end else if (is_store && size == SZ_WORD) begin
            state_nxt = WR;
            wdata_nxt = store_data;
          end else begin
            state_nxt = RD;
          end
        end
      end
      RD:   state_nxt = RESP;
      RESP: begin
        if (req_store) begin
          wdata_nxt = merge_c;
          state_nxt = WR;
        end else begin
          load_nxt  = ext_c;
          state_nxt = DONE;
        end
      end
      WR:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      MemRead        <= 1'b0;
      MemWrite       <= 1'b0;
      load_data      <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      req_store      <= 1'b0;
      req_unsigned   <= 1'b0;
      req_size       <= '0;
      req_off        <= '0;
      req_data       <= '0;
    end else begin
      state          <= state_nxt;
      busy           <= (state_nxt != IDLE);
      done           <= (state_nxt == DONE);
      error          <= err_nxt;
      MemRead        <= (state_nxt == RD);
      MemWrite       <= (state_nxt == WR);
      load_data      <= load_nxt;
      mem_write_data <= wdata_nxt;
      if (capture_c) begin
        req_store    <= is_store;
        req_unsigned <= unsigned_ld;
        req_size     <= size;
        req_off      <= address[1:0];
        req_data     <= store_data[15:0];
        mem_address  <= {address[31:2], 2'b00};
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized traffic against
// an array-based memory reference model. Honours LSU_MISALIGN_TRAP_EN when defined.
`timescale 1ns/1ps
module tb_load_store_unit;
  localparam int unsigned MEM_BYTES = 2048;
  localparam int unsigned MEM_WORDS = MEM_BYTES / 4;
  localparam int          MAX_CYC   = 20;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsigned_ld = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] store_data = '0;
  logic        busy, done, error, MemRead, MemWrite;
  logic [31:0] load_data, mem_address, mem_write_data;
  logic [31:0] mem_read_data = '0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_load = '0;

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic        pl_en = 1'b0;
  int unsigned pl_idx = 0;
  logic [31:0] pl_val = '0;

  always #5 clock = ~clock;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .is_store(is_store), .size(size),
    .unsigned_ld(unsigned_ld), .address(address), .store_data(store_data), .busy(busy),
    .done(done), .error(error), .load_data(load_data), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_read_data(mem_read_data)
  );

  function automatic int unsigned word_idx(input logic [31:0] a);
    return (a >> 2) % MEM_WORDS;
  endfunction

  // Synchronous memory: read data appears the cycle after MemRead.
  always @(posedge clock) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    if (MemRead) mem_read_data <= mem[word_idx(mem_address)];
    if (MemWrite) mem[word_idx(mem_address)] <= mem_write_data;
  end

  task automatic preload(input int unsigned idx, input logic [31:0] val);
    @(negedge clock);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clock); #1;
    pl_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  function automatic logic model_reject(input logic [1:0] sz, input logic [31:0] a);
    logic r;
    r = (sz == 2'b11) || (a >= 32'(MEM_BYTES));
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz == 2'b01 && a % 2 != 0) r = 1'b1;
    if (sz == 2'b10 && a % 4 != 0) r = 1'b1;
`endif
    return r;
  endfunction

  // Reference model: expected latency, memory traffic and error; updates ref_mem and exp_load.
  task automatic model_apply(input logic st, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] d,
                             output int lat, output int rd, output int wr, output logic err);
    int unsigned idx, off, sh;
    logic [31:0] w, v, mask;
    err = model_reject(sz, a);
    lat = 1; rd = 0; wr = 0;
    if (err) return;
    idx = a / 4;
    off = a % 4;
    if (sz == 2'b01) off = (off / 2) * 2;
    sh  = (sz == 2'b00) ? 24 - 8 * off : 16 - 8 * off;
    w   = ref_mem[idx];
    if (!st) begin
      lat = 3; rd = 1;
      if (sz == 2'b00) begin
        v = (w >> sh) % 256;
        if (!uns && v >= 128) v = v - 256;
      end else if (sz == 2'b01) begin
        v = (w >> sh) % 65536;
        if (!uns && v >= 32768) v = v - 65536;
      end else begin
        v = w;
      end
      exp_load = v;
    end else if (sz == 2'b10) begin
      lat = 2; wr = 1;
      ref_mem[idx] = d;
    end else begin
      lat = 4; rd = 1; wr = 1;
      mask = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
      ref_mem[idx] = (w & ~mask) | ((d << sh) & mask);
    end
  endtask

  // Drive one request and observe latency, result, and memory strobes until done.
  task automatic do_txn(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] ld, output logic er,
                        output int n_rd, output int n_wr, output logic both, output logic done2);
    lat = 0; n_rd = 0; n_wr = 0; both = 1'b0;
    @(negedge clock);
    start = 1'b1; is_store = st; size = sz; unsigned_ld = uns; address = a; store_data = d;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 1; k <= MAX_CYC; k++) begin
      if (MemRead) n_rd++;
      if (MemWrite) n_wr++;
      if (MemRead && MemWrite) both = 1'b1;
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clock); #1;
    end
    ld = load_data;
    er = error;
    @(posedge clock); #1;
    done2 = done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if ({busy, done, error, MemRead, MemWrite} !== 5'b0) begin
      n_errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, error, MemRead, MemWrite});
    end
    n_checks++;
    if (load_data !== 32'h0) begin
      n_errors++; $display("FAIL reset_load_data: got %h expected 00000000", load_data);
    end
    n_checks++;
    if (mem_address !== 32'h0 || mem_write_data !== 32'h0) begin
      n_errors++; $display("FAIL reset_mem_bus: got %h/%h expected 0/0", mem_address, mem_write_data);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_load_word();
    int lat, rd, wr, elat, erd, ewr; logic [31:0] ld; logic er, eer, both, d2;
    preload(4, 32'h11223344);
    model_apply(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, elat, erd, ewr, eer);
    do_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, ld, er, rd, wr, both, d2);
    n_checks++;
    if (ld !== 32'h11223344 || er !== 1'b0) begin
      n_errors++; $display("FAIL load_word_data: got %h err %b expected 11223344 err 0", ld, er);
    end
    n_checks++;
    if (lat !== 3 || rd !== 1 || wr !== 0) begin
      n_errors++; $display("FAIL load_word_timing: got lat %0d rd %0d wr %0d expected 3 1 0", lat, rd, wr);
    end
    n_checks++;
    if (d2 !== 1'b0) begin
      n_errors++; $display("FAIL done_pulse_width: got done %b one cycle later expected 0", d2);
    end
  endtask

  task automatic test_byte_load();
    int lat, rd, wr, elat, erd, ewr; logic [31:0] ld; logic er, eer, both, d2;
    preload(4, 32'h112233F4);
    model_apply(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, elat, erd, ewr, eer);
    do_txn(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, ld, er, rd, wr, both, d2);
    n_checks++;
    if (ld !== 32'hFFFFFFF4 || lat !== 3) begin
      n_errors++; $display("FAIL signed_byte_load: got %h lat %0d expected FFFFFFF4 lat 3", ld, lat);
    end
    model_apply(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, elat, erd, ewr, eer);
    do_txn(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, ld, er, rd, wr, both, d2);
    n_checks++;
    if (ld !== 32'h000000F4) begin
      n_errors++; $display("FAIL unsigned_byte_load: got %h expected 000000F4", ld);
    end
  endtask

  task automatic test_byte_store();
    int lat, rd, wr, elat, erd, ewr; logic [31:0] ld; logic er, eer, both, d2;
    preload(4, 32'h11223344);
    model_apply(1'b1, 2'b00, 1'b0, 32'h11, 32'hDEADBEAA, elat, erd, ewr, eer);
    do_txn(1'b1, 2'b00, 1'b0, 32'h11, 32'hDEADBEAA, lat, ld, er, rd, wr, both, d2);
    n_checks++;
    if (mem[4] !== 32'h11AA3344) begin
      n_errors++; $display("FAIL byte_store_merge: got %h expected 11AA3344", mem[4]);
    end
    n_checks++;
    if (lat !== 4 || rd !== 1 || wr !== 1 || er !== 1'b0) begin
      n_errors++; $display("FAIL byte_store_timing: got lat %0d rd %0d wr %0d err %b expected 4 1 1 0", lat, rd, wr, er);
    end
    n_checks++;
    if (ld !== 32'h000000F4) begin
      n_errors++; $display("FAIL store_keeps_load_data: got %h expected 000000F4", ld);
    end
  endtask

  task automatic test_misalign();
    int lat, rd, wr, elat, erd, ewr; logic [31:0] ld; logic er, eer, both, d2;
    preload(4, 32'h11223344);
    model_apply(1'b1, 2'b10, 1'b0, 32'h12, 32'hCAFEF00D, elat, erd, ewr, eer);
    do_txn(1'b1, 2'b10, 1'b0, 32'h12, 32'hCAFEF00D, lat, ld, er, rd, wr, both, d2);
`ifdef LSU_MISALIGN_TRAP_EN
    n_checks++;
    if (er !== 1'b1 || lat !== 1 || wr !== 0 || mem[4] !== 32'h11223344) begin
      n_errors++; $display("FAIL misalign_trap: got err %b lat %0d wr %0d mem %h expected 1 1 0 11223344", er, lat, wr, mem[4]);
    end
`else
    n_checks++;
    if (er !== 1'b0 || lat !== 2 || wr !== 1 || mem[4] !== 32'hCAFEF00D) begin
      n_errors++; $display("FAIL misalign_ignore: got err %b lat %0d wr %0d mem %h expected 0 2 1 CAFEF00D", er, lat, wr, mem[4]);
    end
`endif
  endtask

  task automatic test_out_of_range();
    int lat, rd, wr, elat, erd, ewr; logic [31:0] ld, keep; logic er, eer, both, d2;
    keep = exp_load;
    model_apply(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, elat, erd, ewr, eer);
    do_txn(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, lat, ld, er, rd, wr, both, d2);
    n_checks++;
    if (er !== 1'b1 || rd !== 0 || lat !== 1 || ld !== keep) begin
      n_errors++; $display("FAIL out_of_range: got err %b rd %0d lat %0d ld %h expected 1 0 1 %h", er, rd, lat, ld, keep);
    end
    model_apply(1'b1, 2'b00, 1'b0, 32'h7FF, 32'h5A, elat, erd, ewr, eer);
    do_txn(1'b1, 2'b00, 1'b0, 32'h7FF, 32'h5A, lat, ld, er, rd, wr, both, d2);
    n_checks++;
    if (er !== 1'b0 || lat !== 4 || mem[MEM_WORDS-1] !== ref_mem[MEM_WORDS-1]) begin
      n_errors++; $display("FAIL last_byte_store: got err %b lat %0d mem %h expected 0 4 %h", er, lat, mem[MEM_WORDS-1], ref_mem[MEM_WORDS-1]);
    end
    model_apply(1'b0, 2'b01, 1'b0, 32'h7FE, 32'h0, elat, erd, ewr, eer);
    do_txn(1'b0, 2'b01, 1'b0, 32'h7FE, 32'h0, lat, ld, er, rd, wr, both, d2);
    n_checks++;
    if (er !== 1'b0 || ld !== exp_load) begin
      n_errors++; $display("FAIL last_half_load: got err %b ld %h expected 0 %h", er, ld, exp_load);
    end
  endtask

  task automatic test_busy_ignore();
    int elat, erd, ewr; logic eer;
    preload(16, 32'h89ABCDEF);
    model_apply(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, elat, erd, ewr, eer);
    @(negedge clock);
    start = 1'b1; is_store = 1'b0; size = 2'b10; unsigned_ld = 1'b0; address = 32'h40;
    @(posedge clock); #1;
    address = 32'h80; size = 2'b00;
    @(posedge clock); #1;
    @(posedge clock); #1;
    n_checks++;
    if (done !== 1'b1 || load_data !== exp_load) begin
      n_errors++; $display("FAIL busy_ignore_result: got done %b ld %h expected 1 %h", done, load_data, exp_load);
    end
    @(posedge clock); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_errors++; $display("FAIL busy_ignore_idle: got busy %b done %b expected 0 0", busy, done);
    end
    @(posedge clock); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL busy_ignore_not_queued: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat, rd, wr, elat, erd, ewr, bad; logic [31:0] ld, a, d; logic er, eer, both, d2, st, uns;
    logic [1:0] sz;
    for (int i = 0; i < 200; i++) begin
      st  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a   = ($urandom_range(0, 9) == 0) ? 32'(MEM_BYTES) + $urandom_range(0, 5000)
                                        : $urandom_range(0, MEM_BYTES - 1);
      d   = $urandom;
      model_apply(st, sz, uns, a, d, elat, erd, ewr, eer);
      do_txn(st, sz, uns, a, d, lat, ld, er, rd, wr, both, d2);
      n_checks++;
      if (lat !== elat || er !== eer) begin
        n_errors++; $display("FAIL rand_lat_err[%0d]: got lat %0d err %b expected %0d %b", i, lat, er, elat, eer);
      end
      n_checks++;
      if (ld !== exp_load) begin
        n_errors++; $display("FAIL rand_load_data[%0d]: got %h expected %h", i, ld, exp_load);
      end
      n_checks++;
      if (rd !== erd || wr !== ewr || both !== 1'b0) begin
        n_errors++; $display("FAIL rand_strobes[%0d]: got rd %0d wr %0d both %b expected %0d %0d 0", i, rd, wr, both, erd, ewr);
      end
      if (!eer) begin
        n_checks++;
        if (mem[word_idx(a)] !== ref_mem[word_idx(a)]) begin
          n_errors++; $display("FAIL rand_mem[%0d]: got %h expected %h", i, mem[word_idx(a)], ref_mem[word_idx(a)]);
        end
      end
    end
    bad = 0;
    for (int j = 0; j < int'(MEM_WORDS); j++) if (mem[j] !== ref_mem[j]) bad++;
    n_checks++;
    if (bad !== 0) begin
      n_errors++; $display("FAIL mem_image: got %0d differing words expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, rd, wr, elat, erd, ewr; logic [31:0] ld; logic er, eer, both, d2, seen, pulse;
    preload(8, 32'h55667788);
    @(negedge clock);
    start = 1'b1; is_store = 1'b1; size = 2'b01; unsigned_ld = 1'b0; address = 32'h22; store_data = 32'h0000BEEF;
    @(posedge clock); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < MAX_CYC && !seen; k++) begin
      if (MemWrite) seen = 1'b1;
      else begin @(posedge clock); #1; end
    end
    n_checks++;
    if (seen !== 1'b1) begin
      n_errors++; $display("FAIL rst_mid_reach_wr: got MemWrite never seen expected seen");
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (MemWrite !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid_async: got wr %b busy %b done %b expected 0 0 0", MemWrite, busy, done);
    end
    exp_load = '0;
    pulse = 1'b0;
    repeat (2) begin @(posedge clock); #1; if (done) pulse = 1'b1; end
    @(negedge clock);
    reset_n = 1'b1;
    n_checks++;
    if (pulse !== 1'b0 || mem[8] !== 32'h55667788) begin
      n_errors++; $display("FAIL rst_mid_no_effect: got done %b mem %h expected 0 55667788", pulse, mem[8]);
    end
    model_apply(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, elat, erd, ewr, eer);
    do_txn(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, ld, er, rd, wr, both, d2);
    n_checks++;
    if (ld !== 32'h55667788 || lat !== 3 || er !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid_restart: got %h lat %0d err %b expected 55667788 3 0", ld, lat, er);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    for (int i = 0; i < int'(MEM_WORDS); i++) preload(i, $urandom);
    test_load_word();
    test_byte_load();
    test_byte_store();
    test_misalign();
    test_out_of_range();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
